// File: rtl/blk_col_gen.sv
// Raster-to-block column generator: buffers one 4-line strip per bank of a ping-pong
// line store and replays it as IMG_W column words of 4 vertically adjacent pixels.
`timescale 1ns/1ps
module blk_col_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_i,
  input  logic        pix_ivalid,
  input  logic        pix_isof,
  output logic [31:0] blk_col_o,
  output logic        blk_col_ovalid,
  output logic        blk_col_osob,
  output logic        frame_done,
  output logic        ovf_err
);

  localparam int XW    = $clog2(IMG_W);
  localparam int NS    = IMG_H / 4;
  localparam int SW    = (NS > 1) ? $clog2(NS) : 1;
  localparam int AW    = XW + 1;
  // {bank, x} addressing needs a power-of-two span even when IMG_W is not one
  localparam int DEPTH = 2 ** AW;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [7:0]    mem_q [4][DEPTH];

  logic [XW-1:0] wr_x_q, wr_x_d;
  logic [1:0]    wr_row_q, wr_row_d;
  logic          wr_bank_q, wr_bank_d;
  logic [SW-1:0] wr_strip_q, wr_strip_d;
  logic [1:0]    mem_row;
  logic [XW-1:0] mem_x;
  logic          strip_done;

  logic          pend_q, pend_d;
  logic          pend_bank_q, pend_bank_d;
  logic [SW-1:0] pend_strip_q, pend_strip_d;

  logic [0:0]    state_q, state_d;
  logic [XW-1:0] rd_x_q, rd_x_d;
  logic          rd_bank_q, rd_bank_d;
  logic [SW-1:0] rd_strip_q, rd_strip_d;
  logic          rd_en;
  logic          take;
  logic [AW-1:0] rd_addr;

  logic [31:0]   blk_col_q;
  logic          vld_q;
  logic          sob_q;
  logic          fd_q;
  logic          ovf_q, ovf_d;

  // Write side: raster counters; sof restarts the strip in the current bank.
  always_comb begin
    wr_x_d     = wr_x_q;
    wr_row_d   = wr_row_q;
    wr_bank_d  = wr_bank_q;
    wr_strip_d = wr_strip_q;
    mem_row    = wr_row_q;
    mem_x      = wr_x_q;
    strip_done = 1'b0;
    if (pix_ivalid) begin
      if (pix_isof) begin
        mem_row    = 2'd0;
        mem_x      = '0;
        wr_x_d     = XW'(1);
        wr_row_d   = 2'd0;
        wr_strip_d = '0;
      end else if (wr_x_q == X_LAST) begin
        wr_x_d   = '0;
        wr_row_d = wr_row_q + 2'd1;
        if (wr_row_q == 2'd3) begin
          strip_done = 1'b1;
          wr_bank_d  = ~wr_bank_q;
          wr_strip_d = (wr_strip_q == S_LAST) ? '0 : wr_strip_q + SW'(1);
        end
      end else begin
        wr_x_d = wr_x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pix_ivalid) begin
      mem_q[mem_row][{wr_bank_q, mem_x}] <= pix_i;
    end
  end

  // Read FSM: one column per cycle; a pending strip is picked up on the last column.
  always_comb begin
    state_d    = state_q;
    rd_x_d     = rd_x_q;
    rd_bank_d  = rd_bank_q;
    rd_strip_d = rd_strip_q;
    take       = 1'b0;
    rd_en      = (state_q == S_READ);
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          take       = 1'b1;
          state_d    = S_READ;
          rd_bank_d  = pend_bank_q;
          rd_strip_d = pend_strip_q;
          rd_x_d     = '0;
        end
      end
      S_READ: begin
        if (rd_x_q == X_LAST) begin
          rd_x_d = '0;
          if (pend_q) begin
            take       = 1'b1;
            rd_bank_d  = pend_bank_q;
            rd_strip_d = pend_strip_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          rd_x_d = rd_x_q + XW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A newly completed strip wins over the clear from a simultaneous pickup.
  always_comb begin
    pend_d       = strip_done ? 1'b1 : (take ? 1'b0 : pend_q);
    pend_bank_d  = strip_done ? wr_bank_q : pend_bank_q;
    pend_strip_d = strip_done ? wr_strip_q : pend_strip_q;
    ovf_d        = ovf_q | (strip_done & pend_q & ~take);
  end

  assign rd_addr = {rd_bank_q, rd_x_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_x_q       <= '0;
      wr_row_q     <= 2'd0;
      wr_bank_q    <= 1'b0;
      wr_strip_q   <= '0;
      pend_q       <= 1'b0;
      pend_bank_q  <= 1'b0;
      pend_strip_q <= '0;
      state_q      <= S_IDLE;
      rd_x_q       <= '0;
      rd_bank_q    <= 1'b0;
      rd_strip_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      wr_x_q       <= wr_x_d;
      wr_row_q     <= wr_row_d;
      wr_bank_q    <= wr_bank_d;
      wr_strip_q   <= wr_strip_d;
      pend_q       <= pend_d;
      pend_bank_q  <= pend_bank_d;
      pend_strip_q <= pend_strip_d;
      state_q      <= state_d;
      rd_x_q       <= rd_x_d;
      rd_bank_q    <= rd_bank_d;
      rd_strip_q   <= rd_strip_d;
      ovf_q        <= ovf_d;
    end
  end

  // Output stage: registered memory read plus aligned qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_col_q <= '0;
      vld_q     <= 1'b0;
      sob_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      if (rd_en) begin
        blk_col_q <= {mem_q[3][rd_addr], mem_q[2][rd_addr],
                      mem_q[1][rd_addr], mem_q[0][rd_addr]};
      end
      vld_q <= rd_en;
      sob_q <= rd_en & (rd_x_q[1:0] == 2'd0);
      fd_q  <= rd_en & (rd_x_q == X_LAST) & (rd_strip_q == S_LAST);
    end
  end

  assign blk_col_o      = blk_col_q;
  assign blk_col_ovalid = vld_q;
  assign blk_col_osob   = sob_q;
  assign frame_done     = fd_q;
  assign ovf_err        = ovf_q;

endmodule

// File: tb/tb_blk_col_gen.sv
// Directed bench for blk_col_gen at IMG_W=8, IMG_H=8 with pixel value y*8+x.
`timescale 1ns/1ps
module tb_blk_col_gen;
  localparam int W = 8;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pix_i = '0;
  logic        pix_ivalid = 1'b0;
  logic        pix_isof = 1'b0;
  logic [31:0] blk_col_o;
  logic        blk_col_ovalid;
  logic        blk_col_osob;
  logic        frame_done;
  logic        ovf_err;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  int kedge;

  logic [31:0] wq[$];
  int          cq[$];
  logic        sq[$];
  logic        fq[$];
  int          last_edge[$];

  blk_col_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_i(pix_i), .pix_ivalid(pix_ivalid),
    .pix_isof(pix_isof), .blk_col_o(blk_col_o), .blk_col_ovalid(blk_col_ovalid),
    .blk_col_osob(blk_col_osob), .frame_done(frame_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (blk_col_ovalid) begin
      wq.push_back(blk_col_o);
      cq.push_back(cyc);
      sq.push_back(blk_col_osob);
      fq.push_back(frame_done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int s, input int x);
    logic [7:0] b [4];
    for (int r = 0; r < 4; r++) b[r] = 8'((4 * s + r) * 8 + x);
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic drive(input logic [7:0] p, input logic sof, input logic v);
    pix_i = p; pix_isof = sof; pix_ivalid = v;
    @(posedge clk); #1;
    pix_ivalid = 1'b0; pix_isof = 1'b0;
  endtask

  // Idle cycles carry random data and a random sof that must be ignored.
  task automatic idle(input int n);
    repeat (n) drive(8'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic send_frame(input int gap);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        drive(8'(y * 8 + x), (y == 0 && x == 0), 1'b1);
        if (x == W - 1 && y % 4 == 3) last_edge.push_back(cyc);
        idle(gap);
      end
    end
  endtask

  task automatic clear_q;
    wq.delete(); cq.delete(); sq.delete(); fq.delete(); last_edge.delete();
  endtask

  task automatic check_frames(input string tag, input int nfr);
    int x;
    int s;
    chk({tag, "_count"}, wq.size(), nfr * 16);
    for (int i = 0; i < wq.size() && i < nfr * 16; i++) begin
      x = i % W;
      s = (i / W) % 2;
      chk($sformatf("%s_word%0d", tag, i), wq[i], exp_word(s, x));
      chk($sformatf("%s_sob%0d", tag, i), 32'(sq[i]), 32'(x % 4 == 0));
      chk($sformatf("%s_fd%0d", tag, i), 32'(fq[i]), 32'(s == 1 && x == W - 1));
      if (x == 0) begin
        if (i / W < last_edge.size())
          chk($sformatf("%s_lat%0d", tag, i), cq[i], last_edge[i / W] + 2);
      end else begin
        chk($sformatf("%s_burst%0d", tag, i), cq[i], cq[i - 1] + 1);
      end
    end
  endtask

  initial begin
    int nfd;

    // Reset held with random inputs
    repeat (6) begin
      drive(8'($urandom), 1'($urandom), 1'($urandom));
      chk("rst_word", blk_col_o, 32'h0);
      chk("rst_flags", {28'h0, blk_col_ovalid, blk_col_osob, frame_done, ovf_err}, 32'h0);
    end
    rst_n = 1'b1;
    idle(2);

    // Continuous frame
    clear_q();
    send_frame(0);
    idle(12);
    check_frames("cont", 1);
    if (wq.size() >= 16) begin
      chk("cont_first", wq[0], 32'h18100800);
      chk("cont_second", wq[1], 32'h19110901);
      chk("cont_s0last", wq[7], 32'h1F170F07);
      chk("cont_s1first", wq[8], 32'h38302820);
      chk("cont_last", wq[15], 32'h3F372F27);
    end
    chk("hold_word", blk_col_o, 32'h3F372F27);
    chk("hold_vld", 32'(blk_col_ovalid), 32'h0);
    chk("cont_ovf", 32'(ovf_err), 32'h0);

    // Same frame, one valid pixel every third cycle
    clear_q();
    send_frame(2);
    idle(12);
    check_frames("gap", 1);

    // Partial strip abandoned by a new sof
    clear_q();
    for (int i = 0; i < 10; i++) drive(8'hA0 + 8'(i), 1'b0, 1'b1);
    send_frame(0);
    idle(12);
    check_frames("sof", 1);

    // Reset on the third output word
    clear_q();
    for (int i = 0; i < 32; i++) drive(8'(i), (i == 0), 1'b1);
    idle(4);
    chk("mid_vld", 32'(blk_col_ovalid), 32'h1);
    chk("mid_word", blk_col_o, exp_word(0, 2));
    rst_n = 1'b0;
    #1;
    chk("async_vld", 32'(blk_col_ovalid), 32'h0);
    chk("async_out", {blk_col_o[27:0], blk_col_osob, frame_done, ovf_err, 1'b0}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 31; i++) drive(8'(i), 1'b0, 1'b1);
    idle(10);
    chk("post_rst_none", wq.size(), 0);
    drive(8'd31, 1'b0, 1'b1);
    chk("post_rst_e0", 32'(blk_col_ovalid), 32'h0);
    idle(1);
    chk("post_rst_e1", 32'(blk_col_ovalid), 32'h0);
    idle(1);
    chk("post_rst_e2", 32'(blk_col_ovalid), 32'h1);
    chk("post_rst_word", blk_col_o, 32'h18100800);
    idle(12);
    chk("post_rst_count", wq.size(), 8);

    // Two back-to-back frames
    clear_q();
    send_frame(0);
    send_frame(0);
    idle(12);
    check_frames("b2b", 2);
    nfd = 0;
    foreach (fq[i]) nfd += int'(fq[i]);
    chk("b2b_fd_count", nfd, 2);
    chk("b2b_ovf", 32'(ovf_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
